// File: rtl/hough_vote_accumulator.sv
// hough_vote_accumulator
//   Accumulates Hough votes into a theta x rho RAM of saturating counters. When
//   the voting FSM signals frame done, it drains in-flight votes, scans every
//   bin and reports the first strongest bin, then clears the RAM for the next frame.
// Ports
//   clock        : single clock, all logic on posedge
//   reset        : asynchronous, active-low
//   write_enable : one vote per cycle when high
//   address      : rho bin of the vote (rho + RHO_OFFSET)
//   theta        : theta bin of the vote
//   ready        : frame-done level; a rising edge in ACCUM starts the scan
//   busy         : high while clearing, draining or scanning
//   peak_valid   : one-cycle pulse when peak_* are updated
//   peak_found   : peak_votes >= MIN_VOTES
//   peak_theta   : theta bin of the peak
//   peak_rho     : signed rho of the peak (bin - RHO_OFFSET), 12-bit
//   peak_votes   : vote count of the peak
//   vote_lost    : sticky, a vote was dropped; cleared only by reset
module hough_vote_accumulator #(
  parameter int unsigned RHO_BINS   = 1601,
  parameter int unsigned THETA_BINS = 181,
  parameter int unsigned COUNT_W    = 10,
  parameter int unsigned RHO_OFFSET = 800,
  parameter int unsigned MIN_VOTES  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               write_enable,
  input  logic [10:0]        address,
  input  logic [7:0]         theta,
  input  logic               ready,
  output logic               busy,
  output logic               peak_valid,
  output logic               peak_found,
  output logic [7:0]         peak_theta,
  output logic [11:0]        peak_rho,
  output logic [COUNT_W-1:0] peak_votes,
  output logic               vote_lost
);

  localparam int unsigned N     = THETA_BINS * RHO_BINS;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N - 1);
  localparam logic [10:0]        RHO_LAST = 11'(RHO_BINS - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_SCAN
  } state_t;

  state_t state;

  logic [COUNT_W-1:0] mem [N];
  logic [COUNT_W-1:0] rd_data;

  logic [IDX_W-1:0]   ptr;
  logic               drain_cnt;
  logic               ready_q;

  // vote pipeline: s0 = registered vote, s1 = RAM read done, last = previous write
  logic               s0_valid, s1_valid, last_valid;
  logic [IDX_W-1:0]   s0_idx, s1_idx, last_idx;
  logic [COUNT_W-1:0] last_val;

  // scan bookkeeping
  logic               scan_reading, scan_last, rd_valid;
  logic [7:0]         st, rd_theta, max_theta;
  logic [10:0]        sr, rd_rho, max_rho;
  logic [COUNT_W-1:0] max_val;

  logic               vote_in_range_c;
  logic [IDX_W-1:0]   vote_idx_c;
  logic               ready_rise_c;
  logic [COUNT_W-1:0] fwd_base_c;
  logic [COUNT_W-1:0] inc_val_c;
  logic               ram_we_c;
  logic [IDX_W-1:0]   ram_waddr_c;
  logic [IDX_W-1:0]   ram_raddr_c;
  logic [COUNT_W-1:0] ram_wdata_c;

  assign vote_in_range_c = ({1'b0, address} < 12'(RHO_BINS)) &&
                           ({1'b0, theta} < 9'(THETA_BINS));
  assign vote_idx_c      = IDX_W'(theta) * IDX_W'(RHO_BINS) + IDX_W'(address);
  assign ready_rise_c    = ready & ~ready_q;

  // The s1 read missed the write issued on the same edge; take that value instead.
  assign fwd_base_c = (last_valid && (last_idx == s1_idx)) ? last_val : rd_data;
  assign inc_val_c  = (fwd_base_c == CNT_MAX) ? fwd_base_c : fwd_base_c + COUNT_W'(1);

  // RAM port steering: clear writes zeros, otherwise the vote pipeline writes
  always_comb begin
    ram_we_c    = 1'b0;
    ram_waddr_c = s1_idx;
    ram_wdata_c = inc_val_c;
    ram_raddr_c = s0_idx;
    if (state == S_CLEAR) begin
      ram_we_c    = 1'b1;
      ram_waddr_c = ptr;
      ram_wdata_c = '0;
    end else if (s1_valid) begin
      ram_we_c = 1'b1;
    end
    if (state == S_SCAN) begin
      ram_raddr_c = ptr;
    end
  end

  // Counter RAM, one write and one registered read port
  always_ff @(posedge clock) begin
    if (ram_we_c) begin
      mem[ram_waddr_c] <= ram_wdata_c;
    end
    rd_data <= mem[ram_raddr_c];
  end

  // Control FSM, vote pipeline, scan and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_CLEAR;
      ptr          <= '0;
      drain_cnt    <= 1'b0;
      ready_q      <= 1'b0;
      s0_valid     <= 1'b0;
      s0_idx       <= '0;
      s1_valid     <= 1'b0;
      s1_idx       <= '0;
      last_valid   <= 1'b0;
      last_idx     <= '0;
      last_val     <= '0;
      scan_reading <= 1'b0;
      scan_last    <= 1'b0;
      rd_valid     <= 1'b0;
      st           <= '0;
      sr           <= '0;
      rd_theta     <= '0;
      rd_rho       <= '0;
      max_val      <= '0;
      max_theta    <= '0;
      max_rho      <= '0;
      busy         <= 1'b1;
      peak_valid   <= 1'b0;
      peak_found   <= 1'b0;
      peak_theta   <= '0;
      peak_rho     <= '0;
      peak_votes   <= '0;
      vote_lost    <= 1'b0;
    end else begin
      ready_q    <= ready;
      peak_valid <= 1'b0;
      s0_valid   <= 1'b0;
      s1_valid   <= s0_valid;
      s1_idx     <= s0_idx;
      last_valid <= s1_valid;
      last_idx   <= s1_idx;
      last_val   <= inc_val_c;

      if (write_enable && ((state != S_ACCUM) || !vote_in_range_c)) begin
        vote_lost <= 1'b1;
      end

      case (state)
        S_CLEAR: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == IDX_LAST) begin
            state <= S_ACCUM;
            busy  <= 1'b0;
            ptr   <= '0;
          end
        end

        S_ACCUM: begin
          if (write_enable && vote_in_range_c) begin
            s0_valid <= 1'b1;
            s0_idx   <= vote_idx_c;
          end
          if (ready_rise_c) begin
            state     <= S_DRAIN;
            busy      <= 1'b1;
            drain_cnt <= 1'b0;
          end
        end

        // two cycles let a vote taken on the ready edge reach the RAM
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state        <= S_SCAN;
            ptr          <= '0;
            st           <= '0;
            sr           <= '0;
            scan_reading <= 1'b1;
            scan_last    <= 1'b0;
            rd_valid     <= 1'b0;
            max_val      <= '0;
            max_theta    <= '0;
            max_rho      <= '0;
          end
        end

        S_SCAN: begin
          rd_valid <= scan_reading;
          rd_theta <= st;
          rd_rho   <= sr;
          if (scan_reading) begin
            ptr <= ptr + IDX_W'(1);
            if (sr == RHO_LAST) begin
              sr <= '0;
              st <= st + 8'd1;
            end else begin
              sr <= sr + 11'd1;
            end
            if (ptr == IDX_LAST) begin
              scan_reading <= 1'b0;
            end
          end
          // strictly greater keeps the first maximum in scan order
          if (rd_valid && (rd_data > max_val)) begin
            max_val   <= rd_data;
            max_theta <= rd_theta;
            max_rho   <= rd_rho;
          end
          scan_last <= rd_valid && !scan_reading;
          if (scan_last) begin
            peak_valid <= 1'b1;
            peak_found <= (32'(max_val) >= MIN_VOTES);
            peak_theta <= max_theta;
            peak_rho   <= 12'(max_rho) - 12'(RHO_OFFSET);
            peak_votes <= max_val;
            state      <= S_CLEAR;
            ptr        <= '0;
          end
        end

        default: begin
          state <= S_CLEAR;
          busy  <= 1'b1;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hough_vote_accumulator.sv
// Testbench for hough_vote_accumulator with a 4 x 16 bin array and 4-bit counters.
// Stimulus tasks keep an array of expected bin counts and push the expected peak
// when a frame ends; an independent monitor pops and compares on each peak_valid.
module tb_hough_vote_accumulator;

  localparam int RB  = 16;
  localparam int TB  = 4;
  localparam int CW  = 4;
  localparam int RO  = 8;
  localparam int N   = RB * TB;
  localparam int SAT = 15;
  // ready edge sampled on the first posedge, 2 DRAIN cycles, then N+2 scan cycles
  localparam int PEAK_LAT = 1 + 2 + N + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          write_enable;
  logic [10:0]   address;
  logic [7:0]    theta;
  logic          ready;
  logic          busy;
  logic          peak_valid;
  logic          peak_found;
  logic [7:0]    peak_theta;
  logic [11:0]   peak_rho;
  logic [CW-1:0] peak_votes;
  logic          vote_lost;

  always #5 clock = ~clock;

  hough_vote_accumulator #(
    .RHO_BINS  (RB),
    .THETA_BINS(TB),
    .COUNT_W   (CW),
    .RHO_OFFSET(RO),
    .MIN_VOTES (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .address     (address),
    .theta       (theta),
    .ready       (ready),
    .busy        (busy),
    .peak_valid  (peak_valid),
    .peak_found  (peak_found),
    .peak_theta  (peak_theta),
    .peak_rho    (peak_rho),
    .peak_votes  (peak_votes),
    .vote_lost   (vote_lost)
  );

  typedef struct packed {
    logic          found;
    logic [7:0]    th;
    logic [11:0]   rho;
    logic [CW-1:0] votes;
  } peak_t;

  peak_t exp_q[$];
  peak_t mon_e;
  int    model [TB][RB];
  bit    lost_exp;
  bit    accum_phase;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic clear_model();
    for (int t = 0; t < TB; t++)
      for (int a = 0; a < RB; a++)
        model[t][a] = 0;
  endtask

  // First strictly-greater bin in theta-major order, starting from 0 at bin 0
  function automatic peak_t ref_peak();
    peak_t p;
    int best = 0;
    int bt = 0;
    int ba = 0;
    for (int t = 0; t < TB; t++)
      for (int a = 0; a < RB; a++)
        if (model[t][a] > best) begin
          best = model[t][a];
          bt   = t;
          ba   = a;
        end
    p.found = (best >= 1);
    p.th    = 8'(bt);
    p.rho   = 12'(ba - RO);
    p.votes = CW'(best);
    return p;
  endfunction

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset && peak_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_peak_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("peak_found", int'(peak_found), int'(mon_e.found));
        check("peak_theta", int'(peak_theta), int'(mon_e.th));
        check("peak_rho", int'($signed(peak_rho)), int'($signed(mon_e.rho)));
        check("peak_votes", int'(peak_votes), int'(mon_e.votes));
      end
    end
  end

  task automatic drive(input bit en, input int t, input int a);
    @(negedge clock);
    write_enable = en;
    theta        = 8'(t);
    address      = 11'(a);
    if (en) begin
      if (!accum_phase || t >= TB || a >= RB) lost_exp = 1'b1;
      else if (model[t][a] < SAT) model[t][a]++;
    end
  endtask

  task automatic wait_clear();
    int n = 0;
    do begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end while (busy && n < 200);
    check("clear_cycles", n, N);
  endtask

  // Raise ready (optionally with a vote in the same cycle), then wait for the peak.
  // lost_at: scan cycle carrying a vote that must be dropped; reset_at: cycle to reset.
  task automatic start_scan(input bit with_vote, input int vt, input int va,
                            input int lost_at, input int reset_at);
    int cyc = 0;
    bit got = 1'b0;
    @(negedge clock);
    check("vote_lost", int'(vote_lost), int'(lost_exp));
    ready        = 1'b1;
    write_enable = with_vote;
    theta        = 8'(vt);
    address      = 11'(va);
    if (with_vote) begin
      if (vt >= TB || va >= RB) lost_exp = 1'b1;
      else if (model[vt][va] < SAT) model[vt][va]++;
    end
    exp_q.push_back(ref_peak());
    accum_phase = 1'b0;
    while (!got && cyc < 300) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      write_enable = (cyc == lost_at);
      theta        = 8'd1;
      address      = 11'd1;
      if (cyc == lost_at) lost_exp = 1'b1;
      if (cyc == reset_at) begin
        reset        = 1'b0;
        ready        = 1'b0;
        write_enable = 1'b0;
        #1;
        check("rst_busy", int'(busy), 1);
        check("rst_peak_valid", int'(peak_valid), 0);
        check("rst_peak_found", int'(peak_found), 0);
        check("rst_peak_theta", int'(peak_theta), 0);
        check("rst_peak_rho", int'(peak_rho), 0);
        check("rst_peak_votes", int'(peak_votes), 0);
        check("rst_vote_lost", int'(vote_lost), 0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset    = 1'b1;
        lost_exp = 1'b0;
        clear_model();
        wait_clear();
        accum_phase = 1'b1;
        return;
      end
      if (peak_valid) got = 1'b1;
    end
    check("peak_latency", cyc, PEAK_LAT);
    wait_clear();
    clear_model();
    accum_phase = 1'b1;
    // ready still high: must not retrigger
    repeat (3) drive(0, 0, 0);
    ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    write_enable = 1'b0;
    ready        = 1'b0;
    address      = '0;
    theta        = '0;
    lost_exp     = 1'b0;
    accum_phase  = 1'b0;
    clear_model();
    #1 reset = 1'b0;
    #1;
    check("reset_busy", int'(busy), 1);
    check("reset_peak_valid", int'(peak_valid), 0);
    check("reset_peak_votes", int'(peak_votes), 0);
    check("reset_peak_rho", int'(peak_rho), 0);
    check("reset_vote_lost", int'(vote_lost), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_clear();
    accum_phase = 1'b1;

    // empty frame
    start_scan(0, 0, 0, -1, -1);

    // sparse votes
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 5);
      drive(0, 0, 0);
      drive(0, 0, 0);
    end
    drive(1, 1, 9);
    drive(0, 0, 0);
    drive(1, 1, 9);
    start_scan(0, 0, 0, -1, -1);

    // back-to-back same bin, then saturation
    repeat (5) drive(1, 0, 3);
    start_scan(0, 0, 0, -1, -1);
    repeat (20) drive(1, 0, 3);
    start_scan(0, 0, 0, -1, -1);

    // ties keep the first in scan order
    repeat (2) drive(1, 3, 2);
    repeat (2) drive(1, 1, 4);
    start_scan(0, 0, 0, -1, -1);

    // out-of-range votes and a vote during scan are dropped
    drive(1, 0, 16);
    drive(1, 4, 2);
    drive(0, 0, 0);
    start_scan(0, 0, 0, 30, -1);
    start_scan(0, 0, 0, -1, -1);

    // reset in the middle of a scan, then a clean frame
    repeat (3) drive(1, 2, 7);
    start_scan(0, 0, 0, -1, 40);
    repeat (4) drive(1, 2, 7);
    drive(1, 3, 15);
    start_scan(0, 0, 0, -1, -1);

    // randomized frames, some with a vote on the ready edge
    for (int f = 0; f < 6; f++) begin
      int nv = $urandom_range(0, 30);
      for (int i = 0; i < nv; i++) begin
        int t;
        int a;
        t = ($urandom_range(0, 9) == 0) ? TB : ((f % 2 == 0) ? $urandom_range(0, 1) : $urandom_range(0, TB - 1));
        a = ($urandom_range(0, 9) == 0) ? RB : ((f % 2 == 0) ? $urandom_range(0, 3) : $urandom_range(0, RB - 1));
        drive(1, t, a);
        if ($urandom_range(0, 2) == 0) drive(0, 0, 0);
      end
      start_scan(f % 2, $urandom_range(0, TB - 1), $urandom_range(0, RB - 1),
                 (f == 2) ? 25 : -1, -1);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
